// File: rtl/ex_stage_if.sv
// Upstream (decoded op) and downstream (result) valid/ready channels of ex_stage.
// slave is the stage side, master is the producer/consumer side.
interface ex_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic [4:0]  in_shamt;
  logic [2:0]  in_select;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_op1, in_op2, in_rs1, in_rs2, in_rd, in_wen, in_shamt, in_select,
    output in_ready,
    output out_valid, out_result, out_rd, out_wen, out_illegal,
    input  out_ready
  );

  modport master (
    output in_valid, in_op1, in_op2, in_rs1, in_rs2, in_rd, in_wen, in_shamt, in_select,
    input  in_ready,
    input  out_valid, out_result, out_rd, out_wen, out_illegal,
    output out_ready
  );
endinterface

// File: rtl/ex_stage.sv
// Two-slot execute stage: slot A holds operands and drives the external ALU,
// slot B captures the result and presents it to writeback.
//
// slot state  | meaning
// A empty     | no operation waiting for the ALU
// A full      | operands held, ALU evaluating them this cycle
// B empty     | nothing offered to writeback
// B full      | result offered downstream, held until out_ready
module ex_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  ex_stage_if.slave   bus,
  input  logic        fwd_wen,
  input  logic [4:0]  fwd_rd,
  input  logic [31:0] fwd_data,
  output logic [31:0] alu_operand1,
  output logic [31:0] alu_operand2,
  output logic [4:0]  alu_shamt,
  output logic [2:0]  alu_select,
  input  logic [31:0] alu_result
);

  logic        a_valid_q, a_valid_d;
  logic [31:0] a_op1_q, a_op1_d;
  logic [31:0] a_op2_q, a_op2_d;
  logic [4:0]  a_rs1_q, a_rs1_d;
  logic [4:0]  a_rs2_q, a_rs2_d;
  logic [4:0]  a_rd_q, a_rd_d;
  logic        a_wen_q, a_wen_d;
  logic [4:0]  a_shamt_q, a_shamt_d;
  logic [2:0]  a_select_q, a_select_d;

  logic        b_valid_q, b_valid_d;
  logic [31:0] b_result_q, b_result_d;
  logic [4:0]  b_rd_q, b_rd_d;
  logic        b_wen_q, b_wen_d;
  logic        b_illegal_q, b_illegal_d;

  logic        b_adv;
  logic        in_ready;
  logic        accept;
  logic        xfer;
  logic        wb_wen;
  logic        a_illegal;
  logic        byp1;
  logic        byp2;

  // Register-file write snoop; the load-unit write wins over writeback on the same register.
  function automatic logic [31:0] snoop_op(
    input logic [4:0]  rs,
    input logic [31:0] base,
    input logic        fw_en,
    input logic [4:0]  fw_rd,
    input logic [31:0] fw_data,
    input logic        wb_en,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    logic [31:0] v;
    v = base;
    if (rs != 5'd0) begin
      if (fw_en && (fw_rd == rs)) v = fw_data;
      else if (wb_en && (wb_rd == rs)) v = wb_data;
    end
    return v;
  endfunction

  // Handshake control, bypass muxes and next-state of both slots.
  always_comb begin
    b_adv     = !b_valid_q || bus.out_ready;
    in_ready  = reset_n && (!a_valid_q || b_adv);
    accept    = bus.in_valid && in_ready && !flush;
    xfer      = a_valid_q && b_adv && !flush;
    wb_wen    = b_valid_q && bus.out_ready && b_wen_q;
    a_illegal = a_select_q[2] && a_select_q[1];

    // b_wen is already cleared for illegal entries; b_illegal kept explicit for clarity.
    byp1 = b_valid_q && b_wen_q && (b_rd_q == a_rs1_q) && (a_rs1_q != 5'd0) && !b_illegal_q;
    byp2 = b_valid_q && b_wen_q && (b_rd_q == a_rs2_q) && (a_rs2_q != 5'd0) && !b_illegal_q;

    alu_operand1 = byp1 ? b_result_q : a_op1_q;
    alu_operand2 = byp2 ? b_result_q : a_op2_q;
    alu_shamt    = a_shamt_q;
    alu_select   = a_select_q;

    a_valid_d  = a_valid_q;
    a_rs1_d    = a_rs1_q;
    a_rs2_d    = a_rs2_q;
    a_rd_d     = a_rd_q;
    a_wen_d    = a_wen_q;
    a_shamt_d  = a_shamt_q;
    a_select_d = a_select_q;

    if (flush)       a_valid_d = 1'b0;
    else if (accept) a_valid_d = 1'b1;
    else if (xfer)   a_valid_d = 1'b0;

    if (accept) begin
      a_rs1_d    = bus.in_rs1;
      a_rs2_d    = bus.in_rs2;
      a_rd_d     = bus.in_rd;
      a_wen_d    = bus.in_wen;
      a_shamt_d  = bus.in_shamt;
      a_select_d = bus.in_select;
    end

    // Snoop targets whichever op occupies slot A after this edge, new or held.
    a_op1_d = snoop_op(a_rs1_d, accept ? bus.in_op1 : a_op1_q,
                       fwd_wen, fwd_rd, fwd_data, wb_wen, b_rd_q, b_result_q);
    a_op2_d = snoop_op(a_rs2_d, accept ? bus.in_op2 : a_op2_q,
                       fwd_wen, fwd_rd, fwd_data, wb_wen, b_rd_q, b_result_q);

    b_valid_d   = b_valid_q;
    b_result_d  = b_result_q;
    b_rd_d      = b_rd_q;
    b_wen_d     = b_wen_q;
    b_illegal_d = b_illegal_q;

    if (flush)      b_valid_d = 1'b0;
    else if (xfer)  b_valid_d = 1'b1;
    else if (b_adv) b_valid_d = 1'b0;

    if (xfer) begin
      b_result_d  = a_illegal ? 32'd0 : alu_result;
      b_rd_d      = a_rd_q;
      b_wen_d     = a_wen_q && !a_illegal;
      b_illegal_d = a_illegal;
    end
  end

  // Slot registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_valid_q   <= 1'b0;
      a_op1_q     <= 32'd0;
      a_op2_q     <= 32'd0;
      a_rs1_q     <= 5'd0;
      a_rs2_q     <= 5'd0;
      a_rd_q      <= 5'd0;
      a_wen_q     <= 1'b0;
      a_shamt_q   <= 5'd0;
      a_select_q  <= 3'd0;
      b_valid_q   <= 1'b0;
      b_result_q  <= 32'd0;
      b_rd_q      <= 5'd0;
      b_wen_q     <= 1'b0;
      b_illegal_q <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_op1_q     <= a_op1_d;
      a_op2_q     <= a_op2_d;
      a_rs1_q     <= a_rs1_d;
      a_rs2_q     <= a_rs2_d;
      a_rd_q      <= a_rd_d;
      a_wen_q     <= a_wen_d;
      a_shamt_q   <= a_shamt_d;
      a_select_q  <= a_select_d;
      b_valid_q   <= b_valid_d;
      b_result_q  <= b_result_d;
      b_rd_q      <= b_rd_d;
      b_wen_q     <= b_wen_d;
      b_illegal_q <= b_illegal_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = b_valid_q;
  assign bus.out_result  = b_result_q;
  assign bus.out_rd      = b_rd_q;
  assign bus.out_wen     = b_wen_q;
  assign bus.out_illegal = b_illegal_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage with a behavioural ALU attached to the alu_* ports.
module tb_ex_stage;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND = 3'b010, OR = 3'b011,
                         SHL = 3'b100, SHR = 3'b101;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        fwd_wen;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [31:0] alu_operand1, alu_operand2, alu_result;
  logic [4:0]  alu_shamt;
  logic [2:0]  alu_select;

  int   vectors;
  int   miscompares;
  exp_t q[$];

  ex_stage_if bus ();

  ex_stage u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .bus          (bus),
    .fwd_wen      (fwd_wen),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_shamt    (alu_shamt),
    .alu_select   (alu_select),
    .alu_result   (alu_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU; illegal codes return a poison value the stage must ignore.
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    case (alu_select)
      ADD: alu_result = alu_operand1 + alu_operand2;
      SUB: alu_result = alu_operand1 - alu_operand2;
      AND: alu_result = alu_operand1 & alu_operand2;
      OR:  alu_result = alu_operand1 | alu_operand2;
      SHL: alu_result = alu_operand1 << alu_shamt;
      SHR: alu_result = alu_operand1 >> alu_shamt;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  // Output monitor: every writeback handshake pops and compares one expected entry.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output got result=%h rd=%0d, expected no output", bus.out_result, bus.out_rd);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({bus.out_result, bus.out_rd, bus.out_wen, bus.out_illegal} !== e) begin
          miscompares++;
          $display("FAIL result got res=%h rd=%0d wen=%b ill=%b, expected res=%h rd=%0d wen=%b ill=%b",
                   bus.out_result, bus.out_rd, bus.out_wen, bus.out_illegal, e.res, e.rd, e.wen, e.ill);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [31:0] op1, input logic [31:0] op2, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic wen,
                       input logic [4:0] shamt, input logic [2:0] sel, input logic [31:0] exp_res,
                       input logic exp_wen, input logic exp_ill);
    bit done;
    done = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op1    = op1;
    bus.in_op2    = op2;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_rd     = rd;
    bus.in_wen    = wen;
    bus.in_shamt  = shamt;
    bus.in_select = sel;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        q.push_back('{exp_res, rd, exp_wen, exp_ill});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout in_ready never high, expected accept within 50 cycles");
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 60 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout %0d results still pending, expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %b, expected 0", bus.in_ready); end
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b, expected 0", bus.out_valid); end
    vectors++;
    if (bus.out_result !== 32'd0) begin miscompares++; $display("FAIL rst_out_result got %h, expected 0", bus.out_result); end
    vectors++;
    if (bus.out_rd !== 5'd0) begin miscompares++; $display("FAIL rst_out_rd got %0d, expected 0", bus.out_rd); end
    vectors++;
    if (bus.out_wen !== 1'b0 || bus.out_illegal !== 1'b0) begin
      miscompares++; $display("FAIL rst_out_flags got wen=%b ill=%b, expected 0 0", bus.out_wen, bus.out_illegal);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle();
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_in_ready got %b, expected 1", bus.in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    issue(32'h5, 32'h3, 5'd8, 5'd9, 5'd10, 1'b1, 5'd0, ADD, 32'h8, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early got out_valid=%b, expected 0", bus.out_valid); end
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL latency_two got out_valid=%b, expected 1", bus.out_valid); end
    drain();
  endtask

  task automatic test_dependent();
    logic v1, v2;
    issue(32'h7, 32'h1, 5'd12, 5'd13, 5'd1, 1'b1, 5'd0, ADD, 32'h8, 1'b1, 1'b0);
    issue(32'h0, 32'hFFFF, 5'd1, 5'd0, 5'd2, 1'b1, 5'd4, SHL, 32'h80, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    v1 = bus.out_valid;
    @(posedge clk);
    #1;
    @(negedge clk);
    v2 = bus.out_valid;
    vectors++;
    if (v1 !== 1'b1 || v2 !== 1'b1) begin
      miscompares++; $display("FAIL no_bubble got out_valid=%b,%b, expected 1,1", v1, v2);
    end
    drain();
    // Second op accepted on the edge the first one writes back: stale operand must be snooped.
    issue(32'h20, 32'h3, 5'd14, 5'd15, 5'd6, 1'b1, 5'd0, ADD, 32'h23, 1'b1, 1'b0);
    idle();
    @(posedge clk);
    #1;
    issue(32'h0, 32'h5, 5'd6, 5'd0, 5'd0, 1'b0, 5'd0, ADD, 32'h28, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_alu_ops();
    issue(32'h3, 32'h5, 5'd22, 5'd23, 5'd16, 1'b1, 5'd0, SUB, 32'hFFFF_FFFE, 1'b1, 1'b0);
    issue(32'hF0F0, 32'hFF00, 5'd24, 5'd25, 5'd17, 1'b1, 5'd0, AND, 32'hF000, 1'b1, 1'b0);
    issue(32'h0F00, 32'h00F0, 5'd26, 5'd27, 5'd18, 1'b1, 5'd0, OR, 32'h0FF0, 1'b1, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 5'd28, 5'd29, 5'd19, 1'b1, 5'd31, SHR, 32'h1, 1'b1, 1'b0);
    issue(32'h1, 32'hFFFF_FFFF, 5'd30, 5'd31, 5'd20, 1'b1, 5'd31, SHL, 32'h8000_0000, 1'b1, 1'b0);
    issue(32'hFFFF_FFFF, 32'h2, 5'd22, 5'd23, 5'd21, 1'b1, 5'd0, ADD, 32'h1, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_illegal();
    issue(32'h5, 32'h6, 5'd22, 5'd23, 5'd7, 1'b1, 5'd0, 3'b111, 32'h0, 1'b0, 1'b1);
    issue(32'h33, 32'h10, 5'd7, 5'd24, 5'd8, 1'b1, 5'd0, OR, 32'h33, 1'b1, 1'b0);
    issue(32'h9, 32'h9, 5'd25, 5'd26, 5'd9, 1'b1, 5'd0, 3'b110, 32'h0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_snoop();
    fwd_wen = 1'b1; fwd_rd = 5'd3; fwd_data = 32'h1234_5678;
    issue(32'hAAAA, 32'h1, 5'd3, 5'd24, 5'd9, 1'b1, 5'd0, ADD, 32'h1234_5679, 1'b1, 1'b0);
    fwd_wen = 1'b0;
    drain();
    fwd_wen = 1'b1; fwd_rd = 5'd0; fwd_data = 32'h1234_5678;
    issue(32'hAAAA, 32'h1, 5'd0, 5'd24, 5'd9, 1'b1, 5'd0, ADD, 32'hAAAB, 1'b1, 1'b0);
    fwd_wen = 1'b0;
    drain();
    // Snoop into an op held in slot A during a stall.
    bus.out_ready = 1'b0;
    issue(32'h1, 32'h1, 5'd25, 5'd26, 5'd10, 1'b1, 5'd0, ADD, 32'h2, 1'b1, 1'b0);
    issue(32'h0, 32'h7, 5'd5, 5'd24, 5'd11, 1'b1, 5'd0, ADD, 32'h107, 1'b1, 1'b0);
    idle();
    fwd_wen = 1'b1; fwd_rd = 5'd5; fwd_data = 32'h100;
    @(posedge clk);
    #1;
    fwd_wen = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();
    // Load-unit write beats writeback when both target the same register.
    issue(32'h50, 32'h0, 5'd25, 5'd26, 5'd12, 1'b1, 5'd0, ADD, 32'h50, 1'b1, 1'b0);
    idle();
    @(posedge clk);
    #1;
    fwd_wen = 1'b1; fwd_rd = 5'd12; fwd_data = 32'h999;
    issue(32'h0, 32'h1, 5'd12, 5'd24, 5'd13, 1'b1, 5'd0, ADD, 32'h99A, 1'b1, 1'b0);
    fwd_wen = 1'b0;
    drain();
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    issue(32'h1, 32'h2, 5'd25, 5'd26, 5'd14, 1'b1, 5'd0, ADD, 32'h3, 1'b1, 1'b0);
    issue(32'd10, 32'd20, 5'd25, 5'd26, 5'd15, 1'b1, 5'd0, ADD, 32'h1E, 1'b1, 1'b0);
    bus.in_valid = 1'b1; bus.in_op1 = 32'd100; bus.in_op2 = 32'd200;
    bus.in_rs1 = 5'd25; bus.in_rs2 = 5'd26; bus.in_rd = 5'd16; bus.in_wen = 1'b1;
    bus.in_shamt = 5'd0; bus.in_select = ADD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready cycle %0d got %b, expected 0", i, bus.in_ready); end
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h3 || bus.out_rd !== 5'd14) begin
        miscompares++;
        $display("FAIL stall_hold cycle %0d got v=%b res=%h rd=%0d, expected v=1 res=3 rd=14",
                 i, bus.out_valid, bus.out_result, bus.out_rd);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL stall_release got in_ready=%b, expected 1", bus.in_ready);
    end else begin
      q.push_back('{32'h12C, 5'd16, 1'b1, 1'b0});
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    issue(32'h1, 32'h1, 5'd25, 5'd26, 5'd14, 1'b1, 5'd0, ADD, 32'h2, 1'b1, 1'b0);
    issue(32'h2, 32'h2, 5'd25, 5'd26, 5'd15, 1'b1, 5'd0, ADD, 32'h4, 1'b1, 1'b0);
    bus.in_op1 = 32'h77; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle();
    q.delete();
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL flush_full got out_valid=%b in_ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    // Empty pipe, in_ready high: flush must still drop the offered op.
    bus.in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_drop cycle %0d got out_valid=%b, expected 0", i, bus.out_valid); end
      @(posedge clk);
      #1;
    end
    issue(32'h40, 32'h2, 5'd25, 5'd26, 5'd17, 1'b1, 5'd0, SUB, 32'h3E, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_reset_mid_stall();
    bus.out_ready = 1'b0;
    issue(32'h1, 32'h1, 5'd25, 5'd26, 5'd14, 1'b1, 5'd0, ADD, 32'h2, 1'b1, 1'b0);
    issue(32'h2, 32'h2, 5'd25, 5'd26, 5'd15, 1'b1, 5'd0, ADD, 32'h4, 1'b1, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL rst_stall got out_valid=%b in_ready=%b, expected 0 0", bus.out_valid, bus.in_ready);
    end
    reset_n = 1'b1;
    idle();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_stall_slot_a got out_valid=%b, expected 0", bus.out_valid); end
    @(posedge clk);
    #1;
    issue(32'h10, 32'h20, 5'd25, 5'd26, 5'd18, 1'b1, 5'd0, OR, 32'h30, 1'b1, 1'b0);
    drain();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    flush = 1'b0;
    fwd_wen = 1'b0;
    fwd_rd = 5'd0;
    fwd_data = 32'd0;
    bus.in_valid = 1'b0;
    bus.in_op1 = 32'd0;
    bus.in_op2 = 32'd0;
    bus.in_rs1 = 5'd0;
    bus.in_rs2 = 5'd0;
    bus.in_rd = 5'd0;
    bus.in_wen = 1'b0;
    bus.in_shamt = 5'd0;
    bus.in_select = 3'd0;
    bus.out_ready = 1'b1;

    test_reset();
    test_single();
    test_dependent();
    test_alu_ops();
    test_illegal();
    test_snoop();
    test_stall();
    test_flush();
    test_reset_mid_stall();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Two-slot execute pipeline stage between decode/register-read and writeback. It accepts decoded ALU operations over a valid/ready handshake and holds each one in an operand slot (A). Operand hazards are resolved in slot A by bypass and register-file-write snooping, and slot A drives the combinational ALU. The ALU result is captured in a result slot (B), which presents it downstream over a second valid/ready handshake. Throughput is one operation per cycle. Stalls and flushes are supported.

## Interface
- Parameters: none. The data width is fixed at 32 and the register index width at 5.
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, synchronous and active-low.
- flush  in  1  synchronous kill of slots A and B.
- in_valid  in  1  the decoded operation is valid.
- in_ready  out  1  the stage accepts the operation this cycle.
- in_op1, in_op2  in  32  register-file read data.
- in_rs1, in_rs2  in  5  source register indices.
- in_rd  in  5  destination register index.
- in_wen  in  1  destination write enable.
- in_shamt  in  5  shift amount.
- in_select  in  3  ALU operation code.
- fwd_wen, fwd_rd, fwd_data  in  1/5/32  register-file write from the other writer (load unit).
- alu_operand1, alu_operand2  out  32  ALU operands (combinational from slot A).
- alu_shamt  out  5  ALU shift amount.
- alu_select  out  3  ALU operation code.
- alu_result  in  32  ALU output (combinational).
- out_valid  out  1  result slot B holds a valid entry.
- out_ready  in  1  the writeback stage accepts the entry.
- out_result  out  32  captured result.
- out_rd  out  5  destination register index.
- out_wen  out  1  destination write enable.
- out_illegal  out  1  the entry had an illegal select code.

## Operation
- Slot states: each slot is EMPTY or FULL (a_valid, b_valid).
- b_adv = !b_valid || out_ready.
- in_ready = reset_n && (!a_valid || b_adv).
- Accept: in_valid && in_ready && !flush loads slot A.
- Slot A to B transfer: a_valid && b_adv && !flush loads slot B.
- Select encoding: 000 add, 001 sub, 010 and, 011 or, 100 shl by shamt, 101 logical shr by shamt.
- Illegal select: codes 110 and 111 are illegal. The stage captures out_result = 0, out_illegal = 1 and forces out_wen = 0. alu_result is ignored for these codes.
- Register 0 is hardwired zero: it is never bypassed or snooped, and its operand value passes through as read.
- Bypass (combinational, slot A to ALU): the operand for rsN is slot B's result when b_valid && b_wen && b_rd == rsN && rsN != 0 && !b_illegal. Otherwise it is slot A's stored operand.
- Snoop: at each edge, slot A's stored operands are overwritten on a match with a register-file write.
  - Write sources are fwd_wen and the out handshake (out_valid && out_ready && out_wen).
  - The snoop applies to the occupant that holds slot A after the edge, including an operation accepted on that same edge.
  - The register file has no write-through, so the snoop is mandatory.
  - If both sources target the same register, fwd_data wins.
- Arithmetic is 32-bit modulo 2^32. Overflow and carry are discarded.
- Shifts use alu_shamt only. Bits of operand2 do not affect shifts.

## Timing
- Reset (reset_n low at an edge): a_valid = b_valid = 0, out_result = 0, out_rd = 0, out_wen = 0, out_illegal = 0.
- in_ready = 0 while reset_n is low. After reset is released, in_ready = 1 on the first cycle.
- Latency: an operation accepted at edge N is in slot A during cycle N+1. It is captured in slot B at edge N+1, with out_valid = 1 during cycle N+2.
- Back-to-back dependent operations execute with no bubble, via the slot B bypass.
- Stall: when out_valid && !out_ready, slot B holds. Slot A holds if full, and in_ready = 0 only when slot A is full. out_* remain stable while stalled.
- Flush: at the edge it clears a_valid and b_valid. It takes priority over accept and transfer, so an input offered in the flush cycle is dropped. in_ready follows the formula.
- Simultaneous drain and fill: out handshake, slot A to B transfer and accept occur on the same edge when slot B is full, out_ready = 1 and slot A is full.
- Reset mid-stall discards both slots. No partial handshake survives reset.

## Test plan
- Reset then single op: add 0x00000005 + 0x00000003 accepted at edge 0 -> out_result = 0x00000008 with out_valid = 1 two edges later. All out_* were 0 during reset.
- Dependent chain: r1 = 7 + 1, then r2 = r1(stale 0) << 4 issued next cycle -> second out_result = 0x00000080 with no bubble.
- Stall: out_ready = 0 for 3 cycles with 3 ops offered -> in_ready drops after slot A fills. out_* are stable. All 3 results emerge in order after release.
- Snoop: op in slot A reads rs1 = 3 (stale 0xAAAA) while fwd writes r3 = 0x12345678 -> the op uses 0x12345678. Repeat with r0 -> the op uses the read value.
- Illegal select 111 -> out_illegal = 1, out_result = 0, out_wen = 0. The next op is unaffected.
- Flush with both slots full and in_valid = 1 -> out_valid = 0 next cycle and the offered op is dropped. A later op completes normally.
